// File: rtl/cram_cond_merge_unit.sv
// ============================================================================
//  Module      : cram_cond_merge_unit
//  Description : Per-channel back-prop condition capture with AND/OR/FIRST
//                merge into one registered CRAM sequencer condition.
//                Optional timeout: define CRAM_COND_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cram_cond_merge_unit #(
    parameter int NUM_CH    = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Clr,
    input  logic                 I_Arm,
    input  logic [NUM_CH-1:0]    I_Mask,
    input  logic [1:0]           I_Mode,
    input  logic [NUM_CH-1:0]    I_BTk_v,
    input  logic [NUM_CH-1:0]    I_BTk_c,
    input  logic [TIMEOUT_W-1:0] I_TOLimit,
    output logic [NUM_CH-1:0]    O_Lock,
    output logic                 O_Valid,
    output logic                 O_Cond,
    output logic                 O_Timeout
);

    localparam logic [1:0] c_MODE_OR    = 2'b01;
    localparam logic [1:0] c_MODE_FIRST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [NUM_CH-1:0] r_mask,  w_nxt_mask;
    logic [1:0]        r_mode,  w_nxt_mode;
    logic [NUM_CH-1:0] r_lock,  w_nxt_lock;
    logic [NUM_CH-1:0] r_cap,   w_nxt_cap;
    logic              r_first, w_nxt_first;
    logic              r_valid, w_nxt_valid;
    logic              r_cond,  w_nxt_cond;

    logic [NUM_CH-1:0] w_cap_now;
    logic              w_first_c;
    logic              w_complete;
    logic              w_merge;

`ifdef CRAM_COND_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_timer, w_nxt_timer;
    logic                 r_timeout, w_nxt_timeout;
`else
    logic w_unused_tolimit;
    assign w_unused_tolimit = ^I_TOLimit;
`endif

    assign w_cap_now = I_BTk_v & r_mask & ~r_lock;

    // Descending scan so the lowest capturing channel's bit is the one kept.
    always_comb begin
        w_first_c = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_cap_now[i]) begin
                w_first_c = I_BTk_c[i];
            end
        end
    end

    always_comb begin
        w_complete = ((r_lock & r_mask) == r_mask);
        w_merge    = &(r_cap | ~r_mask);
        if (r_mode == c_MODE_FIRST) begin
            w_complete = |r_lock;
            w_merge    = r_first;
        end else if (r_mode == c_MODE_OR) begin
            w_merge    = |(r_cap & r_mask);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mask  = r_mask;
        w_nxt_mode  = r_mode;
        w_nxt_lock  = r_lock;
        w_nxt_cap   = r_cap;
        w_nxt_first = r_first;
        w_nxt_valid = r_valid;
        w_nxt_cond  = r_cond;
`ifdef CRAM_COND_TIMEOUT_EN
        w_nxt_timer   = r_timer;
        w_nxt_timeout = r_timeout;
`endif
        if (I_Clr) begin
            w_nxt_state = ST_IDLE;
            w_nxt_lock  = '0;
            w_nxt_cap   = '0;
            w_nxt_first = 1'b0;
            w_nxt_valid = 1'b0;
            w_nxt_cond  = 1'b0;
`ifdef CRAM_COND_TIMEOUT_EN
            w_nxt_timer   = '0;
            w_nxt_timeout = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (I_Arm) begin
                        w_nxt_mask  = I_Mask;
                        w_nxt_mode  = I_Mode;
                        w_nxt_lock  = '0;
                        w_nxt_cap   = '0;
                        w_nxt_first = 1'b0;
`ifdef CRAM_COND_TIMEOUT_EN
                        w_nxt_timer = '0;
`endif
                        // Empty mask: AND of nothing is true, OR/FIRST of nothing is false.
                        if (I_Mask == '0) begin
                            w_nxt_state = ST_DONE;
                            w_nxt_valid = 1'b1;
                            w_nxt_cond  = (I_Mode != c_MODE_OR) && (I_Mode != c_MODE_FIRST);
                        end else begin
                            w_nxt_state = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    w_nxt_lock = r_lock | w_cap_now;
                    w_nxt_cap  = (r_cap & ~w_cap_now) | (I_BTk_c & w_cap_now);
                    if ((r_mode == c_MODE_FIRST) && (|w_cap_now) && !(|r_lock)) begin
                        w_nxt_first = w_first_c;
                    end
                    if (w_complete) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_valid = 1'b1;
                        w_nxt_cond  = w_merge;
`ifdef CRAM_COND_TIMEOUT_EN
                    end else if ((I_TOLimit != '0) && (r_timer == I_TOLimit)) begin
                        w_nxt_state   = ST_DONE;
                        w_nxt_valid   = 1'b1;
                        w_nxt_cond    = 1'b0;
                        w_nxt_timeout = 1'b1;
                    end else begin
                        w_nxt_timer = r_timer + TIMEOUT_W'(1);
`endif
                    end
                end
                default: begin
                    // DONE holds everything until cleared.
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_mode  <= 2'b00;
            r_lock  <= '0;
            r_cap   <= '0;
            r_first <= 1'b0;
            r_valid <= 1'b0;
            r_cond  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mask  <= w_nxt_mask;
            r_mode  <= w_nxt_mode;
            r_lock  <= w_nxt_lock;
            r_cap   <= w_nxt_cap;
            r_first <= w_nxt_first;
            r_valid <= w_nxt_valid;
            r_cond  <= w_nxt_cond;
        end
    end

`ifdef CRAM_COND_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timer   <= w_nxt_timer;
            r_timeout <= w_nxt_timeout;
        end
    end
    assign O_Timeout = r_timeout;
`else
    assign O_Timeout = 1'b0;
`endif

    assign O_Lock  = r_lock;
    assign O_Valid = r_valid;
    assign O_Cond  = r_cond;

endmodule

`default_nettype wire

// File: tb/tb_cram_cond_merge_unit.sv
// ============================================================================
//  Module      : tb_cram_cond_merge_unit
//  Description : Directed self-checking bench for cram_cond_merge_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cram_cond_merge_unit;

    localparam int NUM_CH    = 4;
    localparam int TIMEOUT_W = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 I_Clr = 1'b0;
    logic                 I_Arm = 1'b0;
    logic [NUM_CH-1:0]    I_Mask = '0;
    logic [1:0]           I_Mode = 2'b00;
    logic [NUM_CH-1:0]    I_BTk_v = '0;
    logic [NUM_CH-1:0]    I_BTk_c = '0;
    logic [TIMEOUT_W-1:0] I_TOLimit = '0;
    logic [NUM_CH-1:0]    O_Lock;
    logic                 O_Valid;
    logic                 O_Cond;
    logic                 O_Timeout;

    int n_chk  = 0;
    int n_pass = 0;

    cram_cond_merge_unit #(
        .NUM_CH    (NUM_CH),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .I_Clr     (I_Clr),
        .I_Arm     (I_Arm),
        .I_Mask    (I_Mask),
        .I_Mode    (I_Mode),
        .I_BTk_v   (I_BTk_v),
        .I_BTk_c   (I_BTk_c),
        .I_TOLimit (I_TOLimit),
        .O_Lock    (O_Lock),
        .O_Valid   (O_Valid),
        .O_Cond    (O_Cond),
        .O_Timeout (O_Timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input logic [NUM_CH-1:0] mask, input logic [1:0] mode);
        I_Arm  = 1'b1;
        I_Mask = mask;
        I_Mode = mode;
        step();
        I_Arm  = 1'b0;
    endtask

    task automatic tok(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] c);
        I_BTk_v = v;
        I_BTk_c = c;
        step();
        I_BTk_v = '0;
        I_BTk_c = '0;
    endtask

    task automatic clr();
        I_Clr = 1'b1;
        step();
        I_Clr = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_lock",  32'(O_Lock),    32'h0);
        chk("rst_valid", 32'(O_Valid),   32'h0);
        chk("rst_cond",  32'(O_Cond),    32'h0);
        chk("rst_to",    32'(O_Timeout), 32'h0);

        // AND over all four channels, one token per cycle
        arm(4'hF, 2'b00);
        for (int i = 0; i < NUM_CH; i++) begin
            tok(4'(1 << i), 4'hF);
        end
        chk("and_lock",   32'(O_Lock),  32'hF);
        chk("and_early",  32'(O_Valid), 32'h0);
        step();
        chk("and_valid",  32'(O_Valid),   32'h1);
        chk("and_cond",   32'(O_Cond),    32'h1);
        chk("and_to",     32'(O_Timeout), 32'h0);
        clr();
        chk("clr_valid",  32'(O_Valid), 32'h0);
        chk("clr_lock",   32'(O_Lock),  32'h0);

        // OR with an unmasked token that must be dropped
        arm(4'b0101, 2'b01);
        tok(4'b0010, 4'b0010);
        chk("or_unmasked", 32'(O_Lock), 32'h0);
        tok(4'b0001, 4'b0000);
        tok(4'b0100, 4'b0100);
        chk("or_lock_pre", 32'(O_Lock), 32'h5);
        step();
        chk("or_valid", 32'(O_Valid), 32'h1);
        chk("or_cond",  32'(O_Cond),  32'h1);
        chk("or_lock",  32'(O_Lock),  32'h5);
        clr();

        // FIRST: ch3=1 and ch1=0 together, lowest index wins
        arm(4'hF, 2'b10);
        tok(4'b1010, 4'b1000);
        chk("first_lock", 32'(O_Lock), 32'hA);
        step();
        chk("first_valid", 32'(O_Valid), 32'h1);
        chk("first_cond",  32'(O_Cond),  32'h0);
        tok(4'b0001, 4'b0001);
        chk("first_ign_lock", 32'(O_Lock), 32'hA);
        chk("first_ign_cond", 32'(O_Cond), 32'h0);
        clr();

        // AND mask 0011: second ch0 token must not overwrite the first
        arm(4'b0011, 2'b00);
        tok(4'b0001, 4'b0001);
        tok(4'b0001, 4'b0000);
        chk("nowr_lock", 32'(O_Lock), 32'h1);
        tok(4'b0010, 4'b0010);
        step();
        chk("nowr_valid", 32'(O_Valid), 32'h1);
        chk("nowr_cond",  32'(O_Cond),  32'h1);
        clr();
        chk("nowr_clr_lock",  32'(O_Lock),  32'h0);
        chk("nowr_clr_valid", 32'(O_Valid), 32'h0);
        chk("nowr_clr_cond",  32'(O_Cond),  32'h0);

        // Reserved mode behaves as AND: caps 1,0 give 0
        arm(4'b0011, 2'b11);
        tok(4'b0011, 4'b0001);
        step();
        chk("rsv_valid", 32'(O_Valid), 32'h1);
        chk("rsv_cond",  32'(O_Cond),  32'h0);
        clr();

        // Empty mask: AND -> 1, OR -> 0, FIRST -> 0
        arm(4'b0000, 2'b00);
        chk("empty_and_valid", 32'(O_Valid), 32'h1);
        chk("empty_and_cond",  32'(O_Cond),  32'h1);
        clr();
        arm(4'b0000, 2'b01);
        chk("empty_or_valid", 32'(O_Valid), 32'h1);
        chk("empty_or_cond",  32'(O_Cond),  32'h0);
        clr();
        arm(4'b0000, 2'b10);
        chk("empty_first_cond", 32'(O_Cond), 32'h0);
        clr();

        // Asynchronous reset between edges, mid-COLLECT
        arm(4'hF, 2'b00);
        tok(4'b0001, 4'b0001);
        chk("ar_pre_lock", 32'(O_Lock), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_lock",  32'(O_Lock),  32'h0);
        chk("ar_valid", 32'(O_Valid), 32'h0);
        reset = 1'b0;
        step();

        // Asynchronous reset while DONE with cond=1
        arm(4'b0000, 2'b00);
        chk("ar2_pre_cond", 32'(O_Cond), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar2_cond",  32'(O_Cond),  32'h0);
        chk("ar2_valid", 32'(O_Valid), 32'h0);
        reset = 1'b0;
        step();

        // Clear and token in the same cycle: token dropped
        arm(4'hF, 2'b00);
        I_Clr = 1'b1;
        tok(4'hF, 4'hF);
        I_Clr = 1'b0;
        chk("clrtok_lock", 32'(O_Lock), 32'h0);
        tok(4'hF, 4'hF);
        chk("idle_tok_lock", 32'(O_Lock), 32'h0);

        // Clear and arm together: stays IDLE
        I_Clr = 1'b1;
        arm(4'hF, 2'b01);
        I_Clr = 1'b0;
        tok(4'hF, 4'hF);
        chk("clrarm_lock", 32'(O_Lock), 32'h0);
        step();
        chk("clrarm_valid", 32'(O_Valid), 32'h0);

`ifdef CRAM_COND_TIMEOUT_EN
        begin
            bit hit;
            int cyc;
            hit = 1'b0;
            cyc = 0;
            I_TOLimit = 8'd5;
            arm(4'b0011, 2'b00);
            tok(4'b0001, 4'b0001);
            cyc = 1;
            for (int k = 0; k < 20; k++) begin
                if (!hit) begin
                    if (O_Valid) begin
                        hit = 1'b1;
                    end else begin
                        step();
                        cyc++;
                    end
                end
            end
            chk("to_reached", 32'(hit), 32'h1);
            chk("to_not_early", 32'(cyc >= 5), 32'h1);
            chk("to_flag", 32'(O_Timeout), 32'h1);
            chk("to_cond", 32'(O_Cond),    32'h0);
            chk("to_lock", 32'(O_Lock),    32'h1);
            clr();
            chk("to_clr", 32'(O_Timeout), 32'h0);
            I_TOLimit = '0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
